// File: rtl/game_timer.sv
// Minutes:seconds game timer with count-up (saturating) and count-down (expiring) modes.
// Optional best-time record is compiled in when GAME_TIMER_BEST_EN is defined.
`timescale 1ns/1ps

module game_timer #(
    parameter int CLK_FREQ    = 65000000,
    parameter int MIN_WIDTH   = 6,
    parameter int MAX_MINUTES = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 stop,
    input  logic                 mode_down,
    input  logic [MIN_WIDTH-1:0] preset_min,
    input  logic [5:0]           preset_sec,
    output logic [MIN_WIDTH-1:0] minutes,
    output logic [5:0]           seconds,
    output logic                 running,
    output logic                 expired
`ifdef GAME_TIMER_BEST_EN
    ,
    output logic [MIN_WIDTH-1:0] best_minutes,
    output logic [5:0]           best_seconds,
    output logic                 best_valid
`endif
);

    localparam int                   PS_W    = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PS_W-1:0]      PS_LAST = PS_W'(CLK_FREQ - 1);
    localparam logic [MIN_WIDTH-1:0] MAX_MIN = MIN_WIDTH'(MAX_MINUTES);
    localparam logic [5:0]           SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_reg;
    logic [MIN_WIDTH-1:0] min_reg;
    logic [5:0]           sec_reg;
    logic [PS_W-1:0]      ps_reg;
    logic                 mode_reg;
    logic                 running_reg;
    logic                 expired_reg;

    logic [MIN_WIDTH-1:0] load_min_next;
    logic [5:0]           load_sec_next;
    logic                 load_zero;
    logic [MIN_WIDTH-1:0] count_min_next;
    logic [5:0]           count_sec_next;
    logic                 count_zero_next;

    // Load value: 0:00 when counting up, clamped preset when counting down.
    always_comb begin
        load_min_next = '0;
        load_sec_next = '0;
        if (mode_down) begin
            load_min_next = (preset_min > MAX_MIN) ? MAX_MIN : preset_min;
            load_sec_next = (preset_sec > SEC_MAX) ? SEC_MAX : preset_sec;
        end
    end

    assign load_zero = (load_min_next == '0) && (load_sec_next == '0);

    // Value the counter takes on the next tick, in the latched direction.
    always_comb begin
        count_min_next = min_reg;
        count_sec_next = sec_reg;
        if (mode_reg) begin
            if (sec_reg == '0) begin
                count_sec_next = SEC_MAX;
                count_min_next = min_reg - 1'b1;
            end else begin
                count_sec_next = sec_reg - 6'd1;
            end
        end else begin
            if (sec_reg == SEC_MAX) begin
                // At MAX_MINUTES:59 the count simply holds.
                if (min_reg != MAX_MIN) begin
                    count_min_next = min_reg + 1'b1;
                    count_sec_next = '0;
                end
            end else begin
                count_sec_next = sec_reg + 6'd1;
            end
        end
    end

    assign count_zero_next = (count_min_next == '0) && (count_sec_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            min_reg     <= '0;
            sec_reg     <= '0;
            ps_reg      <= '0;
            mode_reg    <= 1'b0;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            expired_reg <= 1'b0;
            if (start) begin
                min_reg  <= load_min_next;
                sec_reg  <= load_sec_next;
                mode_reg <= mode_down;
                ps_reg   <= '0;
                if (mode_down && load_zero) begin
                    // Nothing to count: finish immediately and flag expiry.
                    state_reg   <= DONE;
                    running_reg <= 1'b0;
                    expired_reg <= 1'b1;
                end else begin
                    state_reg   <= RUN;
                    running_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    RUN: begin
                        if (stop) begin
                            state_reg   <= DONE;
                            running_reg <= 1'b0;
                        end else if (pause) begin
                            state_reg   <= PAUSED;
                            running_reg <= 1'b0;
                        end else if (ps_reg == PS_LAST) begin
                            ps_reg  <= '0;
                            min_reg <= count_min_next;
                            sec_reg <= count_sec_next;
                            if (mode_reg && count_zero_next) begin
                                state_reg   <= DONE;
                                running_reg <= 1'b0;
                                expired_reg <= 1'b1;
                            end
                        end else begin
                            ps_reg <= ps_reg + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (stop) begin
                            state_reg   <= DONE;
                            running_reg <= 1'b0;
                        end else if (!pause) begin
                            state_reg   <= RUN;
                            running_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign minutes = min_reg;
    assign seconds = sec_reg;
    assign running = running_reg;
    assign expired = expired_reg;

`ifdef GAME_TIMER_BEST_EN
    logic [MIN_WIDTH-1:0] best_min_reg;
    logic [5:0]           best_sec_reg;
    logic                 best_valid_reg;
    logic                 stop_commit;
    logic                 best_improved;

    // A stop that actually ends a count-up run; start always overrides stop.
    assign stop_commit   = !start && stop && !mode_reg &&
                           ((state_reg == RUN) || (state_reg == PAUSED));
    // Seconds never exceed 59, so concatenated fields compare as a total time.
    assign best_improved = !best_valid_reg ||
                           ({min_reg, sec_reg} < {best_min_reg, best_sec_reg});

    always_ff @(posedge clk) begin
        if (rst) begin
            best_min_reg   <= '0;
            best_sec_reg   <= '0;
            best_valid_reg <= 1'b0;
        end else if (stop_commit && best_improved) begin
            best_min_reg   <= min_reg;
            best_sec_reg   <= sec_reg;
            best_valid_reg <= 1'b1;
        end
    end

    assign best_minutes = best_min_reg;
    assign best_seconds = best_sec_reg;
    assign best_valid   = best_valid_reg;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer with CLK_FREQ=4, MAX_MINUTES=2.
// Best-time checks are included when GAME_TIMER_BEST_EN is defined.
`timescale 1ns/1ps

module tb_game_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic       mode_down = 1'b0;
    logic [5:0] preset_min = '0;
    logic [5:0] preset_sec = '0;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       expired;
`ifdef GAME_TIMER_BEST_EN
    logic [5:0] best_minutes;
    logic [5:0] best_seconds;
    logic       best_valid;
`endif

    game_timer #(
        .CLK_FREQ   (4),
        .MIN_WIDTH  (6),
        .MAX_MINUTES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .mode_down  (mode_down),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .expired    (expired)
`ifdef GAME_TIMER_BEST_EN
        ,
        .best_minutes(best_minutes),
        .best_seconds(best_seconds),
        .best_valid  (best_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] m;
        logic [5:0] s;
        logic       r;
        logic       e;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input int m, input int s, input logic r, input logic e);
        exp_t x;
        x.m = 6'(m);
        x.s = 6'(s);
        x.r = r;
        x.e = e;
        sb_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  x;
        string t;
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() == 0) return;
        x = sb_q.pop_front();
        t = tag_q.pop_front();
        $display("txn %s: %0d:%02d running=%0d expired=%0d (want %0d:%02d running=%0d expired=%0d)",
                 t, minutes, seconds, running, expired, x.m, x.s, x.r, x.e);
        check({t, ".min"}, 32'(minutes), 32'(x.m));
        check({t, ".sec"}, 32'(seconds), 32'(x.s));
        check({t, ".running"}, 32'(running), 32'(x.r));
        check({t, ".expired"}, 32'(expired), 32'(x.e));
    endtask

    // Inputs change and outputs are observed just after the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // After this task the bench sits in cycle 1 (first cycle after the start edge).
    task automatic pulse_start(input logic md, input int pm, input int ps);
        mode_down  = md;
        preset_min = 6'(pm);
        preset_sec = 6'(ps);
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Up run stopped on the tick cycle that would move s -> s+1; that tick is discarded.
    task automatic run_and_stop(input int s);
        push($sformatf("stop_at_%0d", s), 0, s, 1'b0, 1'b0);
        pulse_start(1'b0, 0, 0);
        step(4 * s + 3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);
        pop_check();
    endtask

`ifdef GAME_TIMER_BEST_EN
    task automatic check_best(input string tag, input int m, input int s, input logic v);
        check({tag, ".best_min"}, 32'(best_minutes), 32'(m));
        check({tag, ".best_sec"}, 32'(best_seconds), 32'(s));
        check({tag, ".best_valid"}, 32'(best_valid), 32'(v));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1);
        push("reset", 0, 0, 1'b0, 1'b0);
        do_reset();
        pop_check();
`ifdef GAME_TIMER_BEST_EN
        check_best("reset", 0, 0, 1'b0);
`endif

        // stop and pause have no effect in IDLE
        push("idle_cmds", 0, 0, 1'b0, 1'b0);
        stop = 1'b1;
        step(1);
        stop  = 1'b0;
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        step(1);
        pop_check();

        // Count up: 61 s after 244 cycles, then saturation at 2:59
        push("up_start", 0, 0, 1'b1, 1'b0);
        push("up_61s", 1, 1, 1'b1, 1'b0);
        push("up_sat", 2, 59, 1'b1, 1'b0);
        pulse_start(1'b0, 0, 0);
        pop_check();
        step(244);
        pop_check();
        step(1000);
        pop_check();

        // Countdown from 0:02: expired only in cycle 9
        for (int c = 1; c <= 11; c++) begin
            int left;
            left = (c >= 9) ? 0 : 2 - (c - 1) / 4;
            push($sformatf("down_c%0d", c), 0, left, c < 9, c == 9);
        end
        pulse_start(1'b1, 0, 2);
        for (int c = 1; c <= 11; c++) begin
            pop_check();
            step(1);
        end

        // Preset 0:00 in down mode finishes at once
        push("zero_preset", 0, 0, 1'b0, 1'b1);
        push("zero_after", 0, 0, 1'b0, 1'b0);
        pulse_start(1'b1, 0, 0);
        pop_check();
        step(1);
        pop_check();

        // Preset clamping 5:63 -> 2:59, then one tick down
        push("clamp_load", 2, 59, 1'b1, 1'b0);
        push("clamp_tick", 2, 58, 1'b1, 1'b0);
        pulse_start(1'b1, 5, 63);
        pop_check();
        step(4);
        pop_check();

        // Seconds borrow 1:00 -> 0:59
        push("wrap_load", 1, 0, 1'b1, 1'b0);
        push("wrap_tick", 0, 59, 1'b1, 1'b0);
        pulse_start(1'b1, 1, 0);
        pop_check();
        step(4);
        pop_check();

        // Pause after 3 RUN cycles, held 20 cycles; prescaler resumes at its last value
        pulse_start(1'b0, 0, 0);
        step(3);
        pause = 1'b1;
        push("pause_c5", 0, 0, 1'b0, 1'b0);
        step(1);
        pop_check();
        push("pause_c23", 0, 0, 1'b0, 1'b0);
        step(18);
        pop_check();
        step(1);
        pause = 1'b0;
        push("resume_c25", 0, 0, 1'b1, 1'b0);
        push("resume_c26", 0, 1, 1'b1, 1'b0);
        step(1);
        pop_check();
        step(1);
        pop_check();

`ifdef GAME_TIMER_BEST_EN
        check_best("no_stop_yet", 0, 0, 1'b0);
`endif

        // Stopped up runs: 0:05, 0:03, 0:07
        run_and_stop(5);
        push("done_pause", 0, 5, 1'b0, 1'b0);
        pause = 1'b1;
        step(2);
        pause = 1'b0;
        step(1);
        pop_check();
`ifdef GAME_TIMER_BEST_EN
        check_best("run1", 0, 5, 1'b1);
`endif
        run_and_stop(3);
`ifdef GAME_TIMER_BEST_EN
        check_best("run2", 0, 3, 1'b1);
`endif
        run_and_stop(7);
`ifdef GAME_TIMER_BEST_EN
        check_best("run3", 0, 3, 1'b1);
`endif

        // Reset in the middle of a countdown showing 0:01: no expiry afterwards
        push("rst_pre", 0, 1, 1'b1, 1'b0);
        pulse_start(1'b1, 0, 2);
        step(4);
        pop_check();
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push("rst_mid", 0, 0, 1'b0, 1'b0);
        pop_check();
        for (int c = 0; c < 8; c++) begin
            push($sformatf("rst_quiet%0d", c), 0, 0, 1'b0, 1'b0);
            step(1);
            pop_check();
        end
`ifdef GAME_TIMER_BEST_EN
        check_best("after_rst", 0, 0, 1'b0);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 65000000, clk cycles per one-second tick.
REQ-002 SHALL have parameter MIN_WIDTH, default 6, width of minute fields.
REQ-003 SHALL have parameter MAX_MINUTES, default 59, upper minute bound for count-up saturation.
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  level-sampled; (re)load counter and run.
REQ-007 SHALL have port pause  in  1  level; hold count while high.
REQ-008 SHALL have port stop  in  1  freeze count, enter DONE.
REQ-009 SHALL have port mode_down  in  1  0 = count up from 0:00, 1 = count down from preset.
REQ-010 SHALL have port preset_min  in  MIN_WIDTH  countdown start minutes.
REQ-011 SHALL have port preset_sec  in  6  countdown start seconds.
REQ-012 SHALL have port minutes  out  MIN_WIDTH  current minutes.
REQ-013 SHALL have port seconds  out  6  current seconds, 0..59.
REQ-014 SHALL have port running  out  1  high in RUN state.
REQ-015 SHALL have port expired  out  1  one-cycle pulse when countdown reaches 0:00.
REQ-016 SHALL have ports best_minutes (MIN_WIDTH), best_seconds (6), best_valid (1), out, present only with GAME_TIMER_BEST_EN.

Function
REQ-017 SHALL implement states IDLE, RUN, PAUSED, DONE; command priority rst > start > stop > pause.
REQ-018 SHALL, on start high in any state, load 0:00 (mode_down=0) or preset (mode_down=1), latch mode_down, clear prescaler, enter RUN next cycle.
REQ-019 SHALL clamp preset_sec > 59 to 59 at load; preset_min > MAX_MINUTES clamped to MAX_MINUTES.
REQ-020 SHALL, on start with mode_down=1 and preset 0:00, enter DONE and pulse expired one cycle later.
REQ-021 SHALL run a prescaler 0..CLK_FREQ-1 in RUN only; tick when prescaler = CLK_FREQ-1, prescaler wraps to 0.
REQ-022 SHALL, on tick in up mode, increment seconds; 59 wraps to 0 and increments minutes.
REQ-023 SHALL saturate at MAX_MINUTES:59 in up mode, remaining in RUN with outputs held.
REQ-024 SHALL, on tick in down mode, decrement; seconds 0 wraps to 59 and decrements minutes.
REQ-025 SHALL, when down count reaches 0:00, enter DONE and assert expired for exactly one cycle, coincident with outputs showing 0:00.
REQ-026 SHALL move RUN -> PAUSED while pause high, PAUSED -> RUN when pause low; prescaler value retained across pause.
REQ-027 SHALL move RUN or PAUSED -> DONE on stop; minutes/seconds frozen; stop ignored in IDLE and DONE.
REQ-028 SHALL ignore pause in IDLE and DONE; tick coincident with stop is discarded.
REQ-029 SHALL register all outputs; minutes/seconds change one cycle after the tick cycle.

Reset
REQ-030 SHALL, on rst, enter IDLE; minutes=0, seconds=0, running=0, expired=0, prescaler=0.
REQ-031 SHALL, with GAME_TIMER_BEST_EN, clear best_minutes=0, best_seconds=0, best_valid=0 on rst only.
REQ-032 SHALL abort any count on rst mid-operation with no expired pulse.

Configuration
REQ-033 SHALL use macro GAME_TIMER_BEST_EN: when defined, best-time record included; when undefined, best ports and logic absent, all other behaviour identical.
REQ-034 SHALL, with GAME_TIMER_BEST_EN, on RUN/PAUSED -> DONE via stop in up mode, update best if best_valid=0 or current time < best; set best_valid=1.
REQ-035 SHALL never update best from down mode or from start re-loads.

Verification (CLK_FREQ=4, MAX_MINUTES=2)
REQ-036 SHALL cover: rst, start pulse, mode_down=0, run 244 cycles -> minutes=1, seconds=1, running=1.
REQ-037 SHALL cover: up run 1000 cycles -> saturated at 2:59, running=1.
REQ-038 SHALL cover: mode_down=1, preset 0:02, start -> expired one-cycle pulse at cycle 9 after start, outputs 0:00, state DONE.
REQ-039 SHALL cover: pause high 20 cycles after 3 cycles of RUN -> seconds unchanged during pause, first tick 1 cycle after pause low.
REQ-040 SHALL cover: best enabled, stop at 0:05 then restart, stop at 0:03 -> best 0:03; third run stop at 0:07 -> best stays 0:03.
REQ-041 SHALL cover: rst asserted mid-countdown at 0:01 -> 0:00, IDLE, no expired pulse.
